// File: rtl/doubling_recursion.sv
// 16-bit adder whose carries come from a log-depth KPG prefix network
// (recursive doubling); the 17-bit sum a + b + cin is registered.

// KPG composition, x more significant. Code 10 is treated as kill.
module kpg_op (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [1:0] z
);
  always_comb begin
    z = 2'b00;
    if (x == 2'b01)      z = y;
    else if (x == 2'b11) z = 2'b11;
  end
endmodule

module doubling_recursion #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH:0]   ans
);
  localparam int NPOS   = WIDTH + 1;
  localparam int STAGES = $clog2(NPOS);

  // Slot 0 is the carry-in position (-1); slot p holds bit p-1.
  logic [STAGES:0][NPOS-1:0][1:0] w_st;
  logic [WIDTH-1:0]               w_carry_in;
  logic [WIDTH:0]                 w_sum;

  assign w_st[0][0] = cin ? 2'b11 : 2'b00;

  genvar s, p;
  generate
    for (p = 1; p < NPOS; p++) begin : g_init
      assign w_st[0][p] = {a[p-1] & b[p-1], a[p-1] | b[p-1]};
    end
    for (s = 0; s < STAGES; s++) begin : g_stage
      for (p = 0; p < NPOS; p++) begin : g_pos
        if (p >= (1 << s)) begin : g_op
          kpg_op u_op (
            .x (w_st[s][p]),
            .y (w_st[s][p-(1<<s)]),
            .z (w_st[s+1][p])
          );
        end else begin : g_keep
          assign w_st[s+1][p] = w_st[s][p];
        end
      end
    end
    for (p = 0; p < WIDTH; p++) begin : g_cy
      assign w_carry_in[p] = w_st[STAGES][p][1];
    end
  endgenerate

  assign w_sum = {w_st[STAGES][WIDTH][1], a ^ b ^ w_carry_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ans <= '0;
    else        ans <= w_sum;
  end
endmodule

// File: tb/tb_doubling_recursion.sv
// Scoreboard bench for doubling_recursion: expected sums are queued at drive
// time and popped one edge later when the registered result appears.
module tb_doubling_recursion;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic [16:0] ans;

  logic [16:0] exp_q[$];
  int n_chk = 0, n_err = 0;

  doubling_recursion #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .ans(ans)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [15:0] ta, input logic [15:0] tb_, input logic tc);
    @(negedge clk);
    a = ta; b = tb_; cin = tc;
    exp_q.push_back({1'b0, ta} + {1'b0, tb_} + {16'd0, tc});
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) chk("sum", ans, exp_q.pop_front());
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout got %0d want 0", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    a = 16'h1234; b = 16'h1111; cin = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("rst_hold", ans, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(17'h02345);

    drive(0, 0, 0);      drive(1, 0, 0);      drive(3, 3, 0);
    drive(11, 7, 0);     drive(86, 93, 0);
    drive(783, 15, 0);   drive(783, 47, 0);   drive(783, 139, 0);
    drive(783, 29, 0);   drive(783, 79, 0);
    drive(5560, 8101, 0);
    drive(61560, 60101, 0);
    drive(16'hFFFF, 16'h0000, 1);
    drive(16'hFFFF, 16'hFFFF, 1);
    drive(16'hAAAA, 16'h5555, 0);
    drive(16'hFFFF, 16'h0001, 0);

    // Asynchronous reset pulse between edges, after a nonzero result.
    @(negedge clk);
    chk("pre_rst", ans, 17'h10000);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", ans, 17'h0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10000; i++)
      drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

    repeat (3) @(posedge clk);
    #2 chk("drain", 17'(exp_q.size()), 17'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
